// File: rtl/button_conditioner.sv
// button_conditioner
//   Input stage in front of the ALU. Every raw push-button and switch passes
//   through a 2-FF synchronizer. Each button is then debounced by its own
//   down-the-line counter and FSM. One debounced press produces one
//   single-cycle, one-hot pulse on o_enable, which the ALU uses to latch
//   operand 1, the operation or operand 2 from o_switch.
//
//   Optional feature: define BUTTON_AUTOREPEAT_EN to re-issue a press request
//   every REPEAT_CYCLES cycles while a button is held.
//
// Ports
//   i_clock   in   1              system clock
//   i_reset   in   1              asynchronous, active-low reset
//   i_boton   in   CANT_BOTONES   raw buttons, active-high, asynchronous
//   i_switch  in   CANT_SWITCHES  raw switches, asynchronous
//   o_enable  out  CANT_BOTONES   one-hot, single-cycle press pulse
//   o_switch  out  CANT_SWITCHES  synchronized switches (2-cycle latency)
//
// Per-button FSM
//   state     | meaning
//   IDLE      | released and stable, waiting for a high level
//   ARMING    | high seen, counting stable-high cycles before accepting
//   PRESSED   | press accepted (request issued), waiting for a low level
//   RELEASING | low seen, counting stable-low cycles before accepting

module button_conditioner #(
  parameter int CANT_BOTONES    = 4,
  parameter int CANT_SWITCHES   = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [CANT_BOTONES-1:0]  i_boton,
  input  logic [CANT_SWITCHES-1:0] i_switch,
  output logic [CANT_BOTONES-1:0]  o_enable,
  output logic [CANT_SWITCHES-1:0] o_switch
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } state_t;

  logic [CANT_BOTONES-1:0]  btn_meta;
  logic [CANT_BOTONES-1:0]  btn_sync;
  logic [CANT_SWITCHES-1:0] sw_meta;
  logic [CANT_SWITCHES-1:0] sw_sync;
  logic [CANT_BOTONES-1:0]  press_req;
  logic [CANT_BOTONES-1:0]  grant;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= i_boton;
      btn_sync <= btn_meta;
      sw_meta  <= i_switch;
      sw_sync  <= sw_meta;
    end
  end

  assign o_switch = sw_sync;

  for (genvar b = 0; b < CANT_BOTONES; b++) begin : g_btn
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lvl;
    logic             fsm_req;
    logic             rpt_req;

    assign lvl = btn_sync[b];

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // The counter is cleared on every state change, so it can only reach
    // CNT_LAST while the level has been stable and never wraps.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fsm_req   = 1'b0;
      case (state)
        IDLE: begin
          if (lvl) begin
            state_nxt = ARMING;
            cnt_nxt   = '0;
          end
        end
        ARMING: begin
          if (!lvl) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            fsm_req   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!lvl) begin
            state_nxt = RELEASING;
            cnt_nxt   = '0;
          end
        end
        RELEASING: begin
          if (lvl) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int             RPT_W    = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt;
    logic [RPT_W-1:0] rpt_nxt;

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) rpt <= '0;
      else          rpt <= rpt_nxt;
    end

    // Counts only while held in PRESSED; any other state (including the
    // bounce back to PRESSED from RELEASING) restarts the period from zero.
    always_comb begin
      rpt_nxt = '0;
      rpt_req = 1'b0;
      if (state == PRESSED && lvl) begin
        if (rpt == RPT_LAST) begin
          rpt_req = 1'b1;
        end else begin
          rpt_nxt = rpt + 1'b1;
        end
      end
    end
`else
    assign rpt_req = 1'b0;
`endif

    assign press_req[b] = fsm_req | rpt_req;
  end

`ifndef BUTTON_AUTOREPEAT_EN
  // The repeat period has no hardware in this build.
  if (REPEAT_CYCLES < 2) begin : g_repeat_unused
  end
`endif

  // Lowest index wins; requests losing arbitration are dropped, their FSMs
  // still advance to PRESSED.
  always_comb begin
    grant = '0;
    for (int i = 0; i < CANT_BOTONES; i++) begin
      if (press_req[i] && grant == '0) grant[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) o_enable <= '0;
    else          o_enable <= grant;
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int NB = 4;
  localparam int NS = 6;
  localparam int DB = 4;
  localparam int RP = 10;
  localparam int LAT = DB + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] boton = '0;
  logic [NS-1:0] sw = '0;
  logic [NB-1:0] o_enable;
  logic [NS-1:0] o_switch;

  button_conditioner #(
    .CANT_BOTONES(NB), .CANT_SWITCHES(NS),
    .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_boton(boton), .i_switch(sw),
    .o_enable(o_enable), .o_switch(o_switch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cycle;
    logic [NB-1:0] value;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];

  always @(negedge clk) begin
    if (o_enable !== '0) obs_q.push_back('{cyc, o_enable});
  end

  // Minimal ALU stand-in: latches operands/op on the enables, op 6'h20 adds.
  logic [NS-1:0] alu_a = '0, alu_op = '0, alu_b = '0;
  logic [7:0]    alu_leds;
  always @(posedge clk) begin
    if (o_enable[0]) alu_a  <= o_switch;
    if (o_enable[1]) alu_op <= o_switch;
    if (o_enable[2]) alu_b  <= o_switch;
  end
  assign alu_leds = (alu_op == 6'h20) ? 8'(alu_a) + 8'(alu_b) : 8'h00;

  int errors = 0;
  int checks = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int bit_idx, input int hold);
    int c0;
    c0 = cyc;
    boton[bit_idx] = 1'b1;
    exp_q.push_back('{c0 + LAT, NB'(1) << bit_idx});
    tick(hold);
    boton[bit_idx] = 1'b0;
    tick(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      boton = NB'($urandom);
      sw    = NS'($urandom);
      tick(1);
      checks++;
      if (o_enable !== '0) begin
        errors++;
        $display("FAIL reset_enable: actual=%b required=0000", o_enable);
      end
      checks++;
      if (o_switch !== '0) begin
        errors++;
        $display("FAIL reset_switch: actual=%b required=000000", o_switch);
      end
    end
    boton = '0;
    sw    = 6'b101010;
    #2 rst_n = 1'b1;
    tick(1);
    checks++;
    if (o_switch !== '0 || o_enable !== '0) begin
      errors++;
      $display("FAIL reset_first_cycle: actual sw=%b en=%b required 0/0", o_switch, o_enable);
    end
    tick(1);
    checks++;
    if (o_switch !== 6'b101010) begin
      errors++;
      $display("FAIL reset_sw_latency: actual=%b required=101010", o_switch);
    end
    obs_q.delete();
  endtask

  task automatic test_clean_press();
    press(0, 20);
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL clean_press: actual=none required=%b@%0d", e.value, e.cycle);
      end else begin
        o = obs_q.pop_front();
        if (o.value !== e.value || o.cycle != e.cycle) begin
          errors++;
          $display("FAIL clean_press: actual=%b@%0d required=%b@%0d", o.value, o.cycle, e.value, e.cycle);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL clean_press_extra: actual=%0d extra pulses required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_bounce();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      boton[1] = (i % 2 == 0);
      tick(2);
    end
    boton[1] = 1'b1;
    exp_q.push_back('{c0 + 8 + LAT, 4'b0010});
    tick(20);
    boton[1] = 1'b0;
    tick(12);
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL bounce: actual=none required=%b@%0d", e.value, e.cycle);
      end else begin
        o = obs_q.pop_front();
        if (o.value !== e.value || o.cycle != e.cycle) begin
          errors++;
          $display("FAIL bounce: actual=%b@%0d required=%b@%0d", o.value, o.cycle, e.value, e.cycle);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_extra: actual=%0d extra pulses required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    int c0;
    c0 = cyc;
    boton = 4'b0110;
    exp_q.push_back('{c0 + LAT, 4'b0010});
    tick(20);
    boton = 4'b0000;
    tick(12);
    press(2, 20);
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL simultaneous: actual=none required=%b@%0d", e.value, e.cycle);
      end else begin
        o = obs_q.pop_front();
        if (o.value !== e.value || o.cycle != e.cycle) begin
          errors++;
          $display("FAIL simultaneous: actual=%b@%0d required=%b@%0d", o.value, o.cycle, e.value, e.cycle);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous_extra: actual=%0d extra pulses required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_switch_alu();
    sw = 6'b100000;
    tick(1);
    checks++;
    if (o_switch !== 6'b101010) begin
      errors++;
      $display("FAIL switch_hold: actual=%b required=101010", o_switch);
    end
    tick(1);
    checks++;
    if (o_switch !== 6'b100000) begin
      errors++;
      $display("FAIL switch_latency: actual=%b required=100000", o_switch);
    end
    sw = 6'd5;       tick(3); press(0, 12);
    sw = 6'b100000;  tick(3); press(1, 12);
    sw = 6'd3;       tick(3); press(2, 12);
    checks++;
    if (alu_leds !== 8'd8) begin
      errors++;
      $display("FAIL alu_leds: actual=%0d required=8", alu_leds);
    end
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL switch_alu: actual=none required=%b@%0d", e.value, e.cycle);
      end else begin
        o = obs_q.pop_front();
        if (o.value !== e.value || o.cycle != e.cycle) begin
          errors++;
          $display("FAIL switch_alu: actual=%b@%0d required=%b@%0d", o.value, o.cycle, e.value, e.cycle);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL switch_alu_extra: actual=%0d extra pulses required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_autorepeat();
    int c0;
    c0 = cyc;
    boton[2] = 1'b1;
    exp_q.push_back('{c0 + LAT, 4'b0100});
`ifdef BUTTON_AUTOREPEAT_EN
    for (int k = 1; k <= 3; k++) exp_q.push_back('{c0 + LAT + k * RP, 4'b0100});
`endif
    tick(40);
    boton[2] = 1'b0;
    tick(15);
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL autorepeat: actual=none required=%b@%0d", e.value, e.cycle);
      end else begin
        o = obs_q.pop_front();
        if (o.value !== e.value || o.cycle != e.cycle) begin
          errors++;
          $display("FAIL autorepeat: actual=%b@%0d required=%b@%0d", o.value, o.cycle, e.value, e.cycle);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL autorepeat_extra: actual=%0d extra pulses required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_press();
    boton[3] = 1'b1;
    tick(5);
    rst_n = 1'b0;
    boton[3] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(15);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_press: actual=%0d pulses required=0", obs_q.size());
      obs_q.delete();
    end
    press(3, 15);
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL after_reset_press: actual=none required=%b@%0d", e.value, e.cycle);
      end else begin
        o = obs_q.pop_front();
        if (o.value !== e.value || o.cycle != e.cycle) begin
          errors++;
          $display("FAIL after_reset_press: actual=%b@%0d required=%b@%0d", o.value, o.cycle, e.value, e.cycle);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_extra: actual=%0d extra pulses required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    tick(2);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_switch_alu();
    test_autorepeat();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
